// File: rtl/irrigacao_zonas_if.sv
// Bus between the board switches/sensors and the irrigation controller.
// There is no valid/ready pair here: start is a level that the controller
// samples on every clock but acts on only while idle; stop is a level that
// acts only while a sequence is running; mode/zone_sel/dur are captured on
// the accepted start, and wet is sampled live in the zone-select step.
interface irrigacao_zonas_if #(
  parameter int N_ZONES = 4,
  parameter int DUR_W   = 8
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [3:0]         zone_sel;
  logic [DUR_W-1:0]   dur;
  logic [N_ZONES-1:0] wet;
  logic [N_ZONES-1:0] valve;
  logic               busy;
  logic               done;
  logic [3:0]         cur_zone;
  logic [DUR_W-1:0]   remaining;
  logic [6:0]         seg;

  modport master (
    output start, stop, mode, zone_sel, dur, wet,
    input  valve, busy, done, cur_zone, remaining, seg
  );

  modport slave (
    input  start, stop, mode, zone_sel, dur, wet,
    output valve, busy, done, cur_zone, remaining, seg
  );
endinterface

// File: rtl/irrigacao_zonas.sv
// Multi-zone timed irrigation controller: waters one zone (manual) or all
// zones in order (auto), skips wet zones, shows the active zone on a
// 7-segment digit. All outputs are decoded from registers only.
module irrigacao_zonas #(
  parameter int N_ZONES  = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  irrigacao_zonas_if.slave bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_WATER  = 2'd2
  } state_t;

  localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [4:0]       ZONES5    = 5'(N_ZONES);
  localparam logic [3:0]       LAST_ZONE = 4'(N_ZONES - 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [1:0]         r_mode;
  logic [DUR_W-1:0]   r_dur;
  logic [DUR_W-1:0]   r_rem;
  logic [3:0]         r_zone;
  logic [PW-1:0]      r_pre;
  logic               r_done;

  logic               w_done_nx;
  logic               w_load;
  logic               w_go_water;
  logic               w_step;
  logic               w_adv;
  logic               w_tick;
  logic               w_wet_cur;
  logic               w_last;
  logic               w_finish;
  logic [N_ZONES-1:0] w_zone_oh;
  logic [6:0]         w_seg;

  assign w_zone_oh   = N_ZONES'(1) << r_zone;
  assign w_wet_cur   = |(bus.wet & w_zone_oh);
  assign w_tick      = (r_pre == PRE_LAST);
  assign w_last      = (r_zone == LAST_ZONE);
  // Manual runs one zone; single pass ends after the last zone; continuous never ends.
  assign w_finish    = (r_mode == 2'b01) || ((r_mode == 2'b10) && w_last);
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic: start acceptance, wet skip, tick completion, stop abort.
  always_comb begin
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;
    w_go_water = 1'b0;
    w_step     = 1'b0;
    w_adv      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.mode != 2'b00)) begin
          if ((bus.mode == 2'b01) && ({1'b0, bus.zone_sel} >= ZONES5)) begin
            w_state_nx = S_IDLE;
          end else if (bus.dur == '0) begin
            w_done_nx = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_state_nx = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (bus.stop) begin
          w_state_nx = S_IDLE;
        end else if (w_wet_cur) begin
          w_adv = 1'b1;
        end else begin
          w_go_water = 1'b1;
          w_state_nx = S_WATER;
        end
      end
      S_WATER: begin
        if (bus.stop) begin
          w_state_nx = S_IDLE;
        end else if (w_tick && (r_rem == DUR_W'(1))) begin
          w_adv = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_adv) begin
      if (w_finish) begin
        w_state_nx = S_IDLE;
        w_done_nx  = 1'b1;
      end else begin
        w_state_nx = S_SELECT;
        w_step     = 1'b1;
      end
    end
  end

  // Datapath: latched settings, zone pointer, tick prescaler, remaining counter, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 2'b00;
      r_dur  <= '0;
      r_rem  <= '0;
      r_zone <= 4'd0;
      r_pre  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nx;
      if (w_load) begin
        r_mode <= bus.mode;
        r_dur  <= bus.dur;
        r_zone <= (bus.mode == 2'b01) ? bus.zone_sel : 4'd0;
      end else if (w_step) begin
        r_zone <= w_last ? 4'd0 : r_zone + 4'd1;
      end else if (w_state_nx == S_IDLE) begin
        r_zone <= 4'd0;
      end
      if (w_go_water) begin
        r_rem <= r_dur;
        r_pre <= '0;
      end else if (r_state == S_WATER) begin
        if (w_tick) begin
          r_pre <= '0;
          r_rem <= r_rem - DUR_W'(1);
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end
    end
  end

  // Hex digit decode of the zone pointer, segments {A,B,C,D,E,F,G}.
  always_comb begin
    w_seg = 7'b0000000;
    case (r_zone)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b0000000;
    endcase
  end

  // Output decode from state and registers only.
  always_comb begin
    bus.valve     = '0;
    bus.remaining = '0;
    bus.cur_zone  = 4'd0;
    bus.seg       = 7'b0000000;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = r_done;
    if (r_state == S_WATER) begin
      bus.valve     = w_zone_oh;
      bus.remaining = r_rem;
    end
    if (r_state != S_IDLE) begin
      bus.cur_zone = r_zone;
      bus.seg      = w_seg;
    end
  end

endmodule

// File: tb/tb_irrigacao_zonas.sv
// Bench for irrigacao_zonas: two instances (one tick per clock, and three
// clocks per tick) share one stimulus stream; each is checked every cycle
// against an expected-output trace built from the watering rules.
module tb_irrigacao_zonas;
  localparam int NZ = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [3:0]    zone_sel;
  logic [DW-1:0] dur;
  logic [NZ-1:0] wet;
  logic [1:0]    dbg_a;
  logic [1:0]    dbg_b;

  irrigacao_zonas_if #(.N_ZONES(NZ), .DUR_W(DW)) if_a ();
  irrigacao_zonas_if #(.N_ZONES(NZ), .DUR_W(DW)) if_b ();

  assign if_a.start = start;    assign if_b.start = start;
  assign if_a.stop = stop;      assign if_b.stop = stop;
  assign if_a.mode = mode;      assign if_b.mode = mode;
  assign if_a.zone_sel = zone_sel; assign if_b.zone_sel = zone_sel;
  assign if_a.dur = dur;        assign if_b.dur = dur;
  assign if_a.wet = wet;        assign if_b.wet = wet;

  irrigacao_zonas #(.N_ZONES(NZ), .DUR_W(DW), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .o_dbg_state(dbg_a)
  );
  irrigacao_zonas #(.N_ZONES(NZ), .DUR_W(DW), .TICK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .o_dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NZ-1:0] valve;
    logic          busy;
    logic          done;
    logic [3:0]    cur_zone;
    logic [DW-1:0] rem;
  } exp_t;

  exp_t exp_qa[$];
  exp_t exp_qb[$];
  exp_t seq_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] hex7(input logic [3:0] z);
    logic [6:0] t [16];
    t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return t[z];
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Whole-sequence trace: one entry per clock from the SELECT after start
  // through the done cycle (or a long prefix for continuous mode).
  task automatic build_seq(input int td, input logic [1:0] m, input logic [3:0] zs,
                           input logic [DW-1:0] d, input logic [NZ-1:0] w);
    exp_t e;
    int   z;
    seq_q.delete();
    if (d == 0) begin
      e = '0;
      e.done = 1'b1;
      seq_q.push_back(e);
      return;
    end
    z = (m == 2'b01) ? int'(zs) : 0;
    forever begin
      e = '0;
      e.busy = 1'b1;
      e.cur_zone = 4'(z);
      seq_q.push_back(e);
      if (!w[z]) begin
        for (int r = int'(d); r >= 1; r--) begin
          for (int k = 0; k < td; k++) begin
            e = '0;
            e.busy = 1'b1;
            e.cur_zone = 4'(z);
            e.valve = NZ'(1) << z;
            e.rem = DW'(r);
            seq_q.push_back(e);
          end
        end
      end
      if ((m == 2'b01) || ((m == 2'b10) && (z == NZ - 1))) begin
        e = '0;
        e.done = 1'b1;
        seq_q.push_back(e);
        break;
      end
      z = (z + 1) % NZ;
      if (seq_q.size() > 1000) break;
    end
  endtask

  task automatic check_one(input int d);
    exp_t          e;
    logic [NZ-1:0] av;
    logic          ab;
    logic          ad;
    logic [3:0]    az;
    logic [DW-1:0] ar;
    logic [6:0]    asg;
    string         p;
    e = '0;
    if (d == 0) begin
      p = "a"; av = if_a.valve; ab = if_a.busy; ad = if_a.done;
      az = if_a.cur_zone; ar = if_a.remaining; asg = if_a.seg;
      if (reset) exp_qa.delete();
      else if (exp_qa.size() > 0) e = exp_qa.pop_front();
    end else begin
      p = "b"; av = if_b.valve; ab = if_b.busy; ad = if_b.done;
      az = if_b.cur_zone; ar = if_b.remaining; asg = if_b.seg;
      if (reset) exp_qb.delete();
      else if (exp_qb.size() > 0) e = exp_qb.pop_front();
    end
    chk({p, ".valve"}, av, e.valve);
    chk({p, ".busy"}, ab, e.busy);
    chk({p, ".done"}, ad, e.done);
    chk({p, ".cur_zone"}, az, e.cur_zone);
    chk({p, ".remaining"}, ar, e.rem);
    chk({p, ".seg"}, asg, e.busy ? hex7(e.cur_zone) : 7'b0);
    if (!reset) begin
      if (!e.busy) begin
        if (start && (mode != 2'b00) && !((mode == 2'b01) && (zone_sel >= 4'(NZ)))) begin
          build_seq((d == 0) ? 1 : 3, mode, zone_sel, dur, wet);
          foreach (seq_q[i]) begin
            if (d == 0) exp_qa.push_back(seq_q[i]);
            else        exp_qb.push_back(seq_q[i]);
          end
        end
      end else if (stop) begin
        if (d == 0) exp_qa.delete();
        else        exp_qb.delete();
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check_one(0);
    check_one(1);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (!if_a.busy && !if_b.busy && (exp_qa.size() == 0) && (exp_qb.size() == 0)) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic set_run(input logic [1:0] m, input logic [3:0] zs, input logic [DW-1:0] d);
    mode = m;
    zone_sel = zs;
    dur = d;
    start = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    zone_sel = 4'd0; dur = '0; wet = '0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    wait_idle();

    // Manual run: zone 2, three ticks.
    set_run(2'b01, 4'd2, 8'd3);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk("man.valve", if_a.valve, 4'b0100);
        chk("man.rem", if_a.remaining, 5 - c);
      end else begin
        chk("man.valve", if_a.valve, 0);
      end
      if (c >= 1 && c <= 4) chk("man.seg", if_a.seg, 7'b1101101);
      chk("man.done", if_a.done, (c == 5) ? 1 : 0);
      if (c == 5) chk("man.busy", if_a.busy, 0);
      next_cycle();
      start = 1'b0;
    end
    wait_idle();

    // Auto single pass, zone 1 wet.
    wet = 4'b0010;
    set_run(2'b10, 4'd0, 8'd2);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3)       chk("auto.valve", if_a.valve, 4'b0001);
      else if (c == 6 || c == 7)  chk("auto.valve", if_a.valve, 4'b0100);
      else if (c == 9 || c == 10) chk("auto.valve", if_a.valve, 4'b1000);
      else                        chk("auto.valve", if_a.valve, 0);
      if (c == 4) chk("auto.sel1", if_a.cur_zone, 1);
      if (c == 5) chk("auto.sel2", if_a.cur_zone, 2);
      chk("auto.done", if_a.done, (c == 11) ? 1 : 0);
      next_cycle();
      start = 1'b0;
    end
    wait_idle();
    wet = '0;

    // Abort continuous run with stop in cycle 4, then restart from zone 0.
    set_run(2'b11, 4'd2, 8'd5);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        chk("abort.valve", if_a.valve, 0);
        chk("abort.busy", if_a.busy, 0);
        chk("abort.done", if_a.done, 0);
        chk("abort.b_busy", if_b.busy, 0);
      end
      next_cycle();
      start = 1'b0;
      stop = (c == 3);
    end
    wait_idle();
    set_run(2'b11, 4'd3, 8'd5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("restart.zone", if_a.cur_zone, 0);
      if (c == 2) chk("restart.valve", if_a.valve, 4'b0001);
      next_cycle();
      start = 1'b0;
      stop = (c == 2);
    end
    stop = 1'b0;
    wait_idle();

    // Illegal manual zone: ignored.
    set_run(2'b01, 4'd7, 8'd3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("badzone.busy", if_a.busy, 0);
      chk("badzone.done", if_a.done, 0);
      next_cycle();
      start = 1'b0;
    end

    // Start while busy with changed settings: running sequence unaffected.
    set_run(2'b01, 4'd1, 8'd4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) chk("busystart.valve", if_a.valve, 4'b0010);
      chk("busystart.done", if_a.done, (c == 6) ? 1 : 0);
      next_cycle();
      if (c == 1) set_run(2'b11, 4'd3, 8'd9);
      else start = 1'b0;
    end
    wait_idle();

    // dur == 0: done pulse only.
    set_run(2'b01, 4'd0, 8'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("dur0.valve", if_a.valve, 0);
      chk("dur0.busy", if_a.busy, 0);
      chk("dur0.done", if_a.done, (c == 1) ? 1 : 0);
      next_cycle();
      start = 1'b0;
    end
    wait_idle();

    // Prescaler: three clocks per tick on the second instance.
    set_run(2'b01, 4'd0, 8'd2);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      chk("presc.valve", if_b.valve, (c >= 2 && c <= 7) ? 1 : 0);
      chk("presc.done", if_b.done, (c == 8) ? 1 : 0);
      next_cycle();
      start = 1'b0;
    end
    wait_idle();

    // Asynchronous reset in the middle of a watering period.
    set_run(2'b01, 4'd2, 8'd6);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst.pre_valve", if_a.valve, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("rst.valve", if_a.valve, 0);
    chk("rst.busy", if_a.busy, 0);
    chk("rst.seg", if_a.seg, 0);
    chk("rst.b_valve", if_b.valve, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    wait_idle();
    set_run(2'b01, 4'd1, 8'd2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3) chk("postrst.valve", if_a.valve, 4'b0010);
      chk("postrst.done", if_a.done, (c == 4) ? 1 : 0);
      next_cycle();
      start = 1'b0;
    end
    wait_idle();

    // Randomized runs; wet only changes while both instances are idle.
    for (int it = 0; it < 40; it++) begin
      int n;
      wait_idle();
      wet = NZ'($urandom_range(0, 15));
      set_run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), DW'($urandom_range(0, 5)));
      next_cycle();
      start = 1'b0;
      n = $urandom_range(5, 60);
      for (int i = 0; i < n; i++) begin
        next_cycle();
        start = ($urandom_range(0, 9) == 0);
        if (start) begin
          mode = 2'($urandom_range(0, 3));
          zone_sel = 4'($urandom_range(0, 7));
          dur = DW'($urandom_range(0, 5));
        end
        stop = ($urandom_range(0, 29) == 0);
      end
      next_cycle();
      start = 1'b0;
      stop = 1'b1;
      next_cycle();
      stop = 1'b0;
    end
    wait_idle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
